// File: rtl/div16_8_seq_pkg.sv
// Shared definitions for the 16/8 sequential restoring divider:
// FSM state encodings and default widths.
package div16_8_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      ITER  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int N_DEFAULT  = 8;
   localparam int CW_DEFAULT = 4;

endpackage

// File: rtl/add.sv
// Generic W-bit ripple adder with carry in/out; the divider reuses it as a
// subtractor by feeding the inverted subtrahend and c_in = 1.
module add #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         c_in,
   output logic [W-1:0] sum,
   output logic         c_out
);

   logic [W:0] total;

   assign total = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c_in};
   assign sum   = total[W-1:0];
   assign c_out = total[W];

endmodule

// File: rtl/div_step.sv
// One restoring-division step: shift a dividend bit into the partial
// remainder, subtract the divisor when it fits, emit the quotient bit.
module div_step #(
   parameter int N = 8
) (
   input  logic [N-1:0] r,
   input  logic         in_bit,
   input  logic [N-1:0] y,
   output logic [N-1:0] r_next,
   output logic         q_bit
);

   logic [N:0] t;
   logic [N:0] diff;
   logic       no_borrow;
   logic       unused_diff_msb;

   assign t = {r, in_bit};

   // Carry out of T + ~Y + 1 is set exactly when T >= Y.
   add #(.W(N + 1)) u_sub (
      .a    (t),
      .b    (~{1'b0, y}),
      .c_in (1'b1),
      .sum  (diff),
      .c_out(no_borrow)
   );

   // Remainder stays below Y, so the difference always fits N bits.
   assign unused_diff_msb = diff[N];
   assign q_bit           = no_borrow;
   assign r_next          = no_borrow ? diff[N-1:0] : t[N-1:0];

endmodule

// File: rtl/div16_8_seq.sv
// Sequential 2N/N restoring divider behind valid/ready handshakes; one
// quotient bit per clock after a one-cycle overflow check.
module div16_8_seq
   import div16_8_seq_pkg::*;
#(
   parameter int N  = N_DEFAULT,
   parameter int CW = CW_DEFAULT
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [2*N-1:0] x,
   input  logic [N-1:0]   y,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   q,
   output logic [N-1:0]   r,
   output logic           ovf
);

   state_t          state_q, state_d;
   logic [2*N-1:0]  x_q, x_d;
   logic [N-1:0]    y_q, y_d;
   logic [N-1:0]    rem_q, rem_d;
   logic [N-1:0]    qsh_q, qsh_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    q_q, q_d;
   logic [N-1:0]    r_q, r_d;
   logic            ovf_q, ovf_d;

   logic [N-1:0]    step_rem;
   logic            step_bit;

   div_step #(.N(N)) u_step (
      .r     (rem_q),
      .in_bit(qsh_q[N-1]),
      .y     (y_q),
      .r_next(step_rem),
      .q_bit (step_bit)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      rem_d   = rem_q;
      qsh_d   = qsh_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               x_d     = x;
               y_d     = y;
               state_d = CHECK;
            end
         end
         CHECK: begin
            // A high half >= Y means the quotient needs more than N bits;
            // this also catches division by zero.
            if (x_q[2*N-1:N] >= y_q) begin
               ovf_d   = 1'b1;
               q_d     = '0;
               r_d     = '0;
               state_d = DONE;
            end else begin
               rem_d   = x_q[2*N-1:N];
               qsh_d   = x_q[N-1:0];
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = ITER;
            end
         end
         ITER: begin
            rem_d = step_rem;
            qsh_d = {qsh_q[N-2:0], step_bit};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) begin
               q_d     = {qsh_q[N-2:0], step_bit};
               r_d     = step_rem;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
         rem_q   <= '0;
         qsh_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         rem_q   <= rem_d;
         qsh_q   <= qsh_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign q         = q_q;
   assign r         = r_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_div16_8_seq.sv
// Self-checking bench for div16_8_seq: directed cases plus a random
// back-to-back run, checked through an expected-result queue.
module tb_div16_8_seq;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] r;
      logic       ovf;
   } res_t;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] x;
   logic [7:0]  y;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  q;
   logic [7:0]  r;
   logic        ovf;

   int   n_tests = 0;
   int   n_fail  = 0;
   res_t exp_q[$];

   div16_8_seq dut (
      .clock    (clock),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x        (x),
      .y        (y),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .q        (q),
      .r        (r),
      .ovf      (ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic res_t model(input logic [15:0] xv, input logic [7:0] yv);
      res_t   res;
      int     xi;
      int     yi;
      xi = int'(xv);
      yi = int'(yv);
      if (int'(xv[15:8]) >= yi) begin
         res.q   = 8'd0;
         res.r   = 8'd0;
         res.ovf = 1'b1;
      end else begin
         res.q   = 8'(xi / yi);
         res.r   = 8'(xi % yi);
         res.ovf = 1'b0;
      end
      return res;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Scoreboard: push on accepting edges, pop and compare on hand-off edges.
   always @(negedge clock) begin
      if (!reset) begin
         if (out_valid && out_ready) begin
            res_t e;
            check("sb_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("res_q", 32'(q), 32'(e.q));
               check("res_r", 32'(r), 32'(e.r));
               check("res_ovf", 32'(ovf), 32'(e.ovf));
               $display("[TB] result q=%0d r=%0d ovf=%0d (expected q=%0d r=%0d ovf=%0d)",
                        q, r, ovf, e.q, e.r, e.ovf);
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(x, y));
            $display("[TB] accept x=%0d y=%0d", x, y);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
   endtask

   task automatic run_op(input logic [15:0] xv, input logic [7:0] yv,
                         input int exp_lat, input int hold);
      int   lat;
      res_t held;
      wait_ready();
      x         = xv;
      y         = yv;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(posedge clock); #1;
      in_valid = 1'b0;
      x        = 16'($urandom);
      y        = 8'($urandom);
      lat      = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clock); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'(exp_lat));
      if (hold > 0) begin
         held = {q, r, ovf};
         for (int k = 0; k < hold; k++) begin
            check("hold_res", 32'({q, r, ovf}), 32'(held));
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_out_valid", 32'(out_valid), 32'd1);
            in_valid = ~in_valid;
            @(posedge clock); #1;
         end
         in_valid  = 1'b0;
         out_ready = 1'b1;
      end
      @(posedge clock); #1;
      check("ready_after", 32'(in_ready), 32'd1);
      check("valid_after", 32'(out_valid), 32'd0);
   endtask

   initial begin
      int n;
      logic [7:0] yr;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      x         = '0;
      y         = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_q", 32'(q), 32'd0);
      check("rst_r", 32'(r), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);

      run_op(16'd1000, 8'd7, 9, 0);
      run_op(16'hFEFF, 8'd255, 9, 0);
      run_op(16'hFFFF, 8'd255, 1, 0);
      run_op(16'd1234, 8'd0, 1, 0);
      run_op(16'd5, 8'd10, 9, 5);

      // Abort an operation with reset during its fourth iteration cycle.
      wait_ready();
      x        = 16'd1000;
      y        = 8'd7;
      in_valid = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clock); #1;
         check("abort_no_valid", 32'(out_valid), 32'd0);
      end
      reset = 1'b1;
      exp_q.delete();
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort_in_ready", 32'(in_ready), 32'd1);
      check("abort_q", 32'(q), 32'd0);
      check("abort_r", 32'(r), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      for (int k = 0; k < 10; k++) begin
         @(posedge clock); #1;
         check("abort_quiet", 32'(out_valid), 32'd0);
      end
      run_op(16'd300, 8'd17, 9, 0);

      // Back-to-back random operations with in_valid held high.
      out_ready = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         yr       = 8'($urandom_range(1, 255));
         x        = {8'($urandom_range(0, int'(yr) - 1)), 8'($urandom)};
         y        = yr;
         in_valid = 1'b1;
         wait_ready();
         @(posedge clock); #1;
      end
      in_valid = 1'b0;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 100) begin
         @(posedge clock); #1;
         n++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
